// File: rtl/countdown_pkg.sv
// ---------------------------------------------------------------------------
// countdown_pkg
// Shared definitions for the mm:ss countdown timer controller.
//   state_t         : controller state encoding (IDLE/RUN/PAUSE/DONE)
//   SEC_TENS_MAX    : largest legal tens digit for minutes and seconds (5)
//   DIGIT_MAX       : largest legal BCD digit (9)
//   bcd_inc_wrap59  : two-digit BCD increment that wraps 59 -> 00
// ---------------------------------------------------------------------------
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] DIGIT_MAX    = 4'd9;

    // Returns {tens, ones} after a +1 in the 00..59 range, with wrap to 00.
    function automatic logic [7:0] bcd_inc_wrap59(input logic [3:0] tens,
                                                  input logic [3:0] ones);
        logic [7:0] result;
        if (ones == DIGIT_MAX) begin
            if (tens == SEC_TENS_MAX) begin
                result = 8'h00;
            end else begin
                result = {tens + 4'd1, 4'd0};
            end
        end else begin
            result = {tens, ones + 4'd1};
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_mmss_counter.sv
// ---------------------------------------------------------------------------
// bcd_mmss_counter
// Holds a four-digit BCD mm:ss value and applies clear / increment /
// decrement commands. It has no notion of the controller state; the caller
// decides which command is legal.
//   clk, rst_n          : clock, asynchronous active-low reset
//   clear               : force 00:00 (highest priority)
//   dec                 : subtract one second with borrow (ignored at 00:00)
//   min_inc, sec_inc    : +1 on minutes / seconds, each wrapping 59 -> 00
//   digit_3..digit_0    : mm tens, mm ones, ss tens, ss ones
//   zero                : high when the value is 00:00
// ---------------------------------------------------------------------------
module bcd_mmss_counter
    import countdown_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       dec,
    input  logic       min_inc,
    input  logic       sec_inc,
    output logic [3:0] digit_3,
    output logic [3:0] digit_2,
    output logic [3:0] digit_1,
    output logic [3:0] digit_0,
    output logic       zero
);

    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [7:0] min_plus;
    logic [7:0] sec_plus;

    assign min_plus = bcd_inc_wrap59(min_tens, min_ones);
    assign sec_plus = bcd_inc_wrap59(sec_tens, sec_ones);

    assign zero = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                  (sec_tens == 4'd0) && (sec_ones == 4'd0);

    // Decrement borrows ripple from seconds ones up through minutes tens.
    // Minutes and seconds increments are independent: no carry between them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
        end else if (clear) begin
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
        end else if (dec) begin
            if (!zero) begin
                if (sec_ones != 4'd0) begin
                    sec_ones <= sec_ones - 4'd1;
                end else begin
                    sec_ones <= DIGIT_MAX;
                    if (sec_tens != 4'd0) begin
                        sec_tens <= sec_tens - 4'd1;
                    end else begin
                        sec_tens <= SEC_TENS_MAX;
                        if (min_ones != 4'd0) begin
                            min_ones <= min_ones - 4'd1;
                        end else begin
                            min_ones <= DIGIT_MAX;
                            min_tens <= min_tens - 4'd1;
                        end
                    end
                end
            end
        end else begin
            if (min_inc) begin
                min_tens <= min_plus[7:4];
                min_ones <= min_plus[3:0];
            end
            if (sec_inc) begin
                sec_tens <= sec_plus[7:4];
                sec_ones <= sec_plus[3:0];
            end
        end
    end

    assign digit_3 = min_tens;
    assign digit_2 = min_ones;
    assign digit_1 = sec_tens;
    assign digit_0 = sec_ones;

endmodule

// File: rtl/countdown_ctrl.sv
// ---------------------------------------------------------------------------
// countdown_ctrl
// Sequencing controller for the 4-digit mm:ss countdown timer.
//   clk, rst_n             : clock, asynchronous active-low reset
//   btn_start              : start / pause / resume / acknowledge pulse
//   btn_clear              : abort to IDLE with time 00:00
//   btn_min_inc            : minutes +1 (IDLE only)
//   btn_sec_inc            : seconds +1 (IDLE only)
//   digit_3..digit_0       : BCD digits mm:ss for the display block
//   enable_3..enable_0     : per-digit visibility (leading-zero blank, blink)
//   done                   : high in DONE
//   running                : high in RUN
// Parameters: TICK_DIV cycles per countdown second, BLINK_DIV cycles per
// blink half-period.
// ---------------------------------------------------------------------------
module countdown_ctrl
    import countdown_pkg::*;
#(
    parameter int TICK_DIV  = 1000,
    parameter int BLINK_DIV = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       btn_min_inc,
    input  logic       btn_sec_inc,
    output logic [3:0] digit_3,
    output logic [3:0] digit_2,
    output logic [3:0] digit_1,
    output logic [3:0] digit_0,
    output logic       enable_3,
    output logic       enable_2,
    output logic       enable_1,
    output logic       enable_0,
    output logic       done,
    output logic       running
);

    localparam int               PRE_W    = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam int               BLK_W    = $clog2(BLINK_DIV + 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    state_t           state;
    state_t           state_next;
    logic [PRE_W-1:0] prescaler;
    logic [PRE_W-1:0] prescaler_next;
    logic [BLK_W-1:0] blink_cnt;
    logic             blink_off;
    logic             restart_blink;

    logic             do_clear;
    logic             do_dec;
    logic             do_min;
    logic             do_sec;
    logic             time_zero;
    logic             time_is_one;

    bcd_mmss_counter u_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (do_clear),
        .dec     (do_dec),
        .min_inc (do_min),
        .sec_inc (do_sec),
        .digit_3 (digit_3),
        .digit_2 (digit_2),
        .digit_1 (digit_1),
        .digit_0 (digit_0),
        .zero    (time_zero)
    );

    // The next decrement from 00:01 lands on 00:00, so DONE is entered on
    // the same edge as that decrement.
    assign time_is_one = (digit_3 == 4'd0) && (digit_2 == 4'd0) &&
                         (digit_1 == 4'd0) && (digit_0 == 4'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A tick in RUN is always applied, even when start is pressed on the
    // same cycle; start then only chooses PAUSE unless time ran out.
    // In PAUSE the prescaler simply holds, so resuming finishes the
    // partial second that was interrupted.
    always_comb begin
        state_next     = state;
        prescaler_next = prescaler;
        do_clear       = 1'b0;
        do_dec         = 1'b0;
        do_min         = 1'b0;
        do_sec         = 1'b0;
        restart_blink  = 1'b0;

        if (btn_clear) begin
            state_next     = IDLE;
            prescaler_next = '0;
            do_clear       = 1'b1;
            restart_blink  = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (btn_start) begin
                        if (!time_zero) begin
                            state_next     = RUN;
                            prescaler_next = '0;
                        end
                    end else begin
                        do_min = btn_min_inc;
                        do_sec = btn_sec_inc;
                    end
                end
                RUN: begin
                    if (prescaler == PRE_LAST) begin
                        prescaler_next = '0;
                        do_dec         = 1'b1;
                        if (time_is_one) begin
                            state_next = DONE;
                        end else if (btn_start) begin
                            state_next = PAUSE;
                        end
                    end else if (btn_start) begin
                        state_next = PAUSE;
                    end else begin
                        prescaler_next = prescaler + PRE_W'(1);
                    end
                end
                PAUSE: begin
                    if (btn_start) begin
                        state_next = RUN;
                    end
                end
                DONE: begin
                    if (btn_start) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end

        if (state_next != state) begin
            restart_blink = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler_next;
        end
    end

    // Blink phase starts visible on every state change and only advances
    // while the display is meant to flash (PAUSE and DONE).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (restart_blink) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if ((state == PAUSE) || (state == DONE)) begin
            if (blink_cnt == BLK_LAST) begin
                blink_cnt <= '0;
                blink_off <= !blink_off;
            end else begin
                blink_cnt <= blink_cnt + BLK_W'(1);
            end
        end else begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end
    end

    assign enable_3 = !blink_off && (digit_3 != 4'd0);
    assign enable_2 = !blink_off;
    assign enable_1 = !blink_off;
    assign enable_0 = !blink_off;

    assign done    = (state == DONE);
    assign running = (state == RUN);

endmodule

// File: tb/tb_countdown_ctrl.sv
// ---------------------------------------------------------------------------
// tb_countdown_ctrl
// Directed self-checking bench for countdown_ctrl with TICK_DIV=4 and
// BLINK_DIV=2. A vector table covers the IDLE editing behaviour; hand
// sequences cover counting, pause/resume, blinking and async reset.
// ---------------------------------------------------------------------------
module tb_countdown_ctrl;

    typedef struct packed {
        logic [3:0] d3;
        logic [3:0] d2;
        logic [3:0] d1;
        logic [3:0] d0;
        logic [3:0] en;
        logic       dn;
        logic       rn;
    } out_t;

    typedef struct {
        logic  start;
        logic  clear;
        logic  min_inc;
        logic  sec_inc;
        out_t  exp;
        string name;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       btn_start;
    logic       btn_clear;
    logic       btn_min_inc;
    logic       btn_sec_inc;
    logic [3:0] digit_3;
    logic [3:0] digit_2;
    logic [3:0] digit_1;
    logic [3:0] digit_0;
    logic       enable_3;
    logic       enable_2;
    logic       enable_1;
    logic       enable_0;
    logic       done;
    logic       running;

    int total;
    int bad;

    vec_t vecs[10];

    countdown_ctrl #(
        .TICK_DIV  (4),
        .BLINK_DIV (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_start   (btn_start),
        .btn_clear   (btn_clear),
        .btn_min_inc (btn_min_inc),
        .btn_sec_inc (btn_sec_inc),
        .digit_3     (digit_3),
        .digit_2     (digit_2),
        .digit_1     (digit_1),
        .digit_0     (digit_0),
        .enable_3    (enable_3),
        .enable_2    (enable_2),
        .enable_1    (enable_1),
        .enable_0    (enable_0),
        .done        (done),
        .running     (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs for time mm:ss; vis=0 means blink-off phase.
    function automatic out_t mk(input int mm, input int ss, input bit vis,
                                input bit dn, input bit rn);
        out_t o;
        o.d3 = 4'(mm / 10);
        o.d2 = 4'(mm % 10);
        o.d1 = 4'(ss / 10);
        o.d0 = 4'(ss % 10);
        if (vis) o.en = {(mm >= 10), 3'b111};
        else     o.en = 4'b0000;
        o.dn = dn;
        o.rn = rn;
        return o;
    endfunction

    // Blink-off phase k cycles after a state entry, for BLINK_DIV=2.
    function automatic bit vis_after(input int k);
        return ((k / 2) % 2) == 0;
    endfunction

    // Drives one cycle of button pulses and returns #1 after the edge.
    task automatic applyStimulus(input logic s, input logic c,
                                 input logic mi, input logic si);
        btn_start   = s;
        btn_clear   = c;
        btn_min_inc = mi;
        btn_sec_inc = si;
        @(posedge clk);
        #1;
        btn_start   = 1'b0;
        btn_clear   = 1'b0;
        btn_min_inc = 1'b0;
        btn_sec_inc = 1'b0;
    endtask

    task automatic checkOutput(input string name, input out_t exp);
        out_t act;
        act = {digit_3, digit_2, digit_1, digit_0,
               enable_3, enable_2, enable_1, enable_0, done, running};
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got d=%h%h:%h%h en=%b done=%b run=%b, want d=%h%h:%h%h en=%b done=%b run=%b",
                     name, act.d3, act.d2, act.d1, act.d0, act.en, act.dn, act.rn,
                     exp.d3, exp.d2, exp.d1, exp.d0, exp.en, exp.dn, exp.rn);
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        btn_start   = 1'b0;
        btn_clear   = 1'b0;
        btn_min_inc = 1'b0;
        btn_sec_inc = 1'b0;

        #2;
        checkOutput("reset", mk(0, 0, 1, 0, 0));
        #10;
        rst_n = 1'b1;

        // IDLE editing vectors: {start, clear, min, sec, expected, name}
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, mk(0, 1, 1, 0, 0), "sec_inc_1"};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, mk(0, 2, 1, 0, 0), "sec_inc_2"};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, mk(0, 3, 1, 0, 0), "sec_inc_3"};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, mk(1, 3, 1, 0, 0), "min_inc_1"};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, mk(2, 4, 1, 0, 0), "both_inc"};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 0,    mk(2, 4, 1, 0, 1), "start_run"};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b1, mk(2, 4, 1, 0, 1), "inc_in_run"};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, mk(0, 0, 1, 0, 0), "clear"};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, mk(0, 0, 1, 0, 0), "start_at_zero"};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 1, 0, 0), "idle_hold"};

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].start, vecs[i].clear,
                          vecs[i].min_inc, vecs[i].sec_inc);
            checkOutput(vecs[i].name, vecs[i].exp);
        end

        // Seconds wrap 59 -> 00 without carrying into minutes.
        for (int i = 0; i < 59; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("sec_59", mk(0, 59, 1, 0, 0));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("sec_wrap", mk(0, 0, 1, 0, 0));

        // Minutes: BCD carry at 09 -> 10, then wrap 59 -> 00.
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("min_10", mk(10, 0, 1, 0, 0));
        for (int i = 0; i < 49; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("min_59", mk(59, 0, 1, 0, 0));
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("min_wrap", mk(0, 0, 1, 0, 0));

        // Count 01:00 down to 00:00, one decrement every 4 cycles.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("set_0100", mk(1, 0, 1, 0, 0));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("run_0100", mk(1, 0, 1, 0, 1));
        for (int t = 59; t >= 0; t--) begin
            for (int c = 0; c < 3; c++) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
                checkOutput($sformatf("hold_%0d", t + 1),
                            mk((t + 1) / 60, (t + 1) % 60, 1, 0, 1));
            end
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            if (t == 0) checkOutput("done_edge", mk(0, 0, 1, 1, 0));
            else        checkOutput($sformatf("dec_%0d", t), mk(0, t, 1, 0, 1));
        end

        // DONE blinks 2 on / 2 off; time stays 00:00.
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("done_blink_%0d", k), mk(0, 0, vis_after(k), 1, 0));
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("done_ack", mk(0, 0, 1, 0, 0));

        // Pause at prescaler=2, hold 20 cycles, resume finishes the second.
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("set_0005", mk(0, 5, 1, 0, 0));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("pre_2", mk(0, 5, 1, 0, 1));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("pause", mk(0, 5, 1, 0, 0));
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("pause_blink_%0d", k), mk(0, 5, vis_after(k), 0, 0));
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("resume", mk(0, 5, 1, 0, 1));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("resume_1", mk(0, 5, 1, 0, 1));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("resume_dec", mk(0, 4, 1, 0, 1));

        // Start coinciding with a tick: decrement then PAUSE.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("pre_3", mk(0, 4, 1, 0, 1));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("tick_and_pause", mk(0, 3, 1, 0, 0));

        // Clear beats start in the same cycle.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("run_0003", mk(0, 3, 1, 0, 1));
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("clear_over_start", mk(0, 0, 1, 0, 0));

        // Asynchronous reset in the middle of RUN, between clock edges.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("pre_reset_run", mk(0, 3, 1, 0, 1));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", mk(0, 0, 1, 0, 0));
        #4;
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("after_reset", mk(0, 0, 1, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
